rf_1r_1w_32_32_arb: RTL

Two-requester arbiter and sequencer for the 32-entry x 32-bit one-read/one-write register file. Shares the single read port between read requesters A and B and the single write port between write requesters A and B, with independent round-robin arbitration on each port. Registers all RAM-side signals, returns read data with fixed latency, and resolves same-cycle read/write address collisions so every read is coherent.

---
 rtl/rf_1r_1w_32_32_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rf_1r_1w_32_32_arb.sv
// rf_1r_1w_32_32_arb: round-robin sharing of a 1R/1W 32x32 register file
// between two readers and two writers, with registered RAM-side signals.
module rf_1r_1w_32_32_arb #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        rf_clock,
    input  logic        rf_reset,
    input  logic        rd_req_a,
    input  logic        rd_req_b,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic        rd_ack_a,
    output logic        rd_ack_b,
    output logic        rd_valid_a,
    output logic        rd_valid_b,
    output logic [31:0] rd_data_a,
    output logic [31:0] rd_data_b,
    input  logic        wr_req_a,
    input  logic        wr_req_b,
    input  logic [4:0]  wr_addr_a,
    input  logic [4:0]  wr_addr_b,
    input  logic [31:0] wr_data_a,
    input  logic [31:0] wr_data_b,
    output logic        wr_ack_a,
    output logic        wr_ack_b,
    output logic [4:0]  rf_rd_addr_0,
    input  logic [31:0] rf_rd_data_0,
    output logic        rf_wr_enable,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic        rd_last_q, rd_last_d;
    logic        wr_last_q, wr_last_d;
    logic        wr_gnt_a, wr_gnt_b, wr_gnt;
    logic [4:0]  wr_sel_addr;
    logic [31:0] wr_sel_data;
    logic        rd_pick_a, rd_pick_b, rd_pick;
    logic [4:0]  rd_sel_addr;
    logic        rd_coll, rd_block;
    logic        rd_gnt_a, rd_gnt_b, rd_gnt;

    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        s1_vld_q, s1_vld_d;
    logic        s1_port_q, s1_port_d;
    logic        s1_hit_q, s1_hit_d;
    logic [31:0] s1_byp_q, s1_byp_d;
    logic        vld_a_q, vld_a_d;
    logic        vld_b_q, vld_b_d;
    logic [31:0] dat_a_q, dat_a_d;
    logic [31:0] dat_b_q, dat_b_d;
    logic [31:0] ret_data;

    always_comb begin
        wr_gnt_a = ~rf_reset & wr_req_a
                 & (~wr_req_b | (wr_last_q == PORT_B));
        wr_gnt_b = ~rf_reset & wr_req_b & ~wr_gnt_a
                 & (~wr_req_a | (wr_last_q == PORT_A));
        wr_gnt   = wr_gnt_a | wr_gnt_b;
        wr_sel_addr = wr_gnt_a ? wr_addr_a : wr_addr_b;
        wr_sel_data = wr_gnt_a ? wr_data_a : wr_data_b;

        rd_pick_a = rd_req_a & (~rd_req_b | (rd_last_q == PORT_B));
        rd_pick_b = rd_req_b & ~rd_pick_a;
        rd_pick   = rd_pick_a | rd_pick_b;
        rd_sel_addr = rd_pick_a ? rd_addr_a : rd_addr_b;

        // A same-cycle write to the read address would land on the same
        // RAM edge as the read; either forward it or hold the read off.
        rd_coll  = rd_pick & wr_gnt & (rd_sel_addr == wr_sel_addr);
        rd_block = ~BYPASS & rd_coll;
        rd_gnt_a = ~rf_reset & rd_pick_a & ~rd_block;
        rd_gnt_b = ~rf_reset & rd_pick_b & ~rd_block;
        rd_gnt   = rd_gnt_a | rd_gnt_b;
    end

    always_comb begin
        rd_last_d = rd_last_q;
        if (rd_gnt) rd_last_d = rd_gnt_b ? PORT_B : PORT_A;
        wr_last_d = wr_last_q;
        if (wr_gnt) wr_last_d = wr_gnt_b ? PORT_B : PORT_A;

        wr_en_d   = wr_gnt;
        wr_addr_d = wr_gnt ? wr_sel_addr : wr_addr_q;
        wr_data_d = wr_gnt ? wr_sel_data : wr_data_q;

        rd_addr_d = rd_gnt ? rd_sel_addr : rd_addr_q;
        s1_vld_d  = rd_gnt;
        s1_port_d = rd_gnt ? rd_gnt_b : s1_port_q;
        s1_hit_d  = BYPASS & rd_gnt & rd_coll;
        s1_byp_d  = wr_sel_data;

        ret_data = s1_hit_q ? s1_byp_q : rf_rd_data_0;
        vld_a_d  = s1_vld_q & (s1_port_q == PORT_A);
        vld_b_d  = s1_vld_q & (s1_port_q == PORT_B);
        dat_a_d  = vld_a_d ? ret_data : dat_a_q;
        dat_b_d  = vld_b_d ? ret_data : dat_b_q;
    end

    always_ff @(posedge rf_clock) begin
        if (rf_reset) begin
            rd_last_q <= PORT_B;
            wr_last_q <= PORT_B;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_port_q <= PORT_A;
            s1_hit_q  <= 1'b0;
            s1_byp_q  <= '0;
            vld_a_q   <= 1'b0;
            vld_b_q   <= 1'b0;
            dat_a_q   <= '0;
            dat_b_q   <= '0;
        end else begin
            rd_last_q <= rd_last_d;
            wr_last_q <= wr_last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            s1_vld_q  <= s1_vld_d;
            s1_port_q <= s1_port_d;
            s1_hit_q  <= s1_hit_d;
            s1_byp_q  <= s1_byp_d;
            vld_a_q   <= vld_a_d;
            vld_b_q   <= vld_b_d;
            dat_a_q   <= dat_a_d;
            dat_b_q   <= dat_b_d;
        end
    end

    assign rd_ack_a     = rd_gnt_a;
    assign rd_ack_b     = rd_gnt_b;
    assign wr_ack_a     = wr_gnt_a;
    assign wr_ack_b     = wr_gnt_b;
    assign rd_valid_a   = vld_a_q;
    assign rd_valid_b   = vld_b_q;
    assign rd_data_a    = dat_a_q;
    assign rd_data_b    = dat_b_q;
    assign rf_rd_addr_0 = rd_addr_q;
    assign rf_wr_enable = wr_en_q;
    assign rf_wr_addr   = wr_addr_q;
    assign rf_wr_data   = wr_data_q;
endmodule
